// File: rtl/io_ctrl_pkg.sv
// io_ctrl_pkg: shared status-word layout, default status address and the status word builder.
package io_ctrl_pkg;
    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_LEVEL_LSB = 4;
    localparam int STATUS_LEVEL_W   = 5;
    localparam int ENTRY_W          = 36;
    localparam logic [3:0] DEFAULT_STATUS_ADDR = 4'hF;

    function automatic logic [31:0] status_word(input logic busy, input logic full, input logic ovf,
                                                input logic [STATUS_LEVEL_W-1:0] lvl);
        status_word = '0;
        status_word[STATUS_BUSY_BIT] = busy;
        status_word[STATUS_FULL_BIT] = full;
        status_word[STATUS_OVF_BIT] = ovf;
        status_word[STATUS_LEVEL_LSB +: STATUS_LEVEL_W] = lvl;
    endfunction
endpackage

// File: rtl/io_write_scheduler_if.sv
// io_write_scheduler_if: peripheral write bus with valid/ready handshake and read-data return.
//   master (scheduler): drives PerValid/PerAddr/PerData, receives PerReady/PerRdData
//   slave  (peripheral): the mirror image
interface io_write_scheduler_if;
    logic        PerValid;
    logic [3:0]  PerAddr;
    logic [31:0] PerData;
    logic        PerReady;
    logic [31:0] PerRdData;

    modport master (output PerValid, output PerAddr, output PerData, input PerReady, input PerRdData);
    modport slave  (input PerValid, input PerAddr, input PerData, output PerReady, output PerRdData);
endinterface

// File: rtl/io_fifo.sv
// io_fifo: synchronous FIFO, head presented from registered storage.
//   CLK/RESET: clock, sync active-high reset
//   push/din: write an entry (ignored when full unless popping the same cycle)
//   pop: retire the head (ignored when empty)
//   dout: head entry; count/full/empty: occupancy
module io_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        mem_d = mem_q;
        if (do_push) mem_d[wr_ptr_q] = din;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK) mem_q <= mem_d;

    assign dout = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
endmodule

// File: rtl/io_write_scheduler.sv
// io_write_scheduler: buffers single-cycle CPU I/O writes and replays them over a valid/ready bus.
//   CLK/RESET: clock, sync active-high reset
//   IOWriteEn/IOAddr/IOWriteData: CPU write port; STATUS_ADDR writes are local (bit 2 clears overflow)
//   IOReadData: status word at STATUS_ADDR, otherwise peripheral read data
//   per: peripheral bus (master side)
module io_write_scheduler
    import io_ctrl_pkg::*;
#(
    parameter int         DEPTH       = 4,
    parameter logic [3:0] STATUS_ADDR = DEFAULT_STATUS_ADDR
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 IOWriteEn,
    input  logic [3:0]           IOAddr,
    input  logic [31:0]          IOWriteData,
    output logic [31:0]          IOReadData,
    io_write_scheduler_if.master per
);
    localparam int CW = $clog2(DEPTH+1);

    logic [ENTRY_W-1:0] head;
    logic [CW-1:0]      count;
    logic               full, empty, is_status, push_req, push, pop;
    logic               overflow_q, overflow_d;

    io_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .CLK(CLK),
        .RESET(RESET),
        .push(push),
        .pop(pop),
        .din({IOAddr, IOWriteData}),
        .dout(head),
        .count(count),
        .full(full),
        .empty(empty)
    );

    // A full FIFO still accepts when the head retires in the same cycle.
    always_comb begin
        is_status = IOAddr == STATUS_ADDR;
        push_req = IOWriteEn && !is_status;
        pop = !empty && per.PerReady;
        push = push_req && (!full || pop);
        overflow_d = (push_req && !push) ? 1'b1 :
                     (IOWriteEn && is_status && IOWriteData[STATUS_OVF_BIT]) ? 1'b0 : overflow_q;
        IOReadData = is_status ? status_word(!empty, full, overflow_q, STATUS_LEVEL_W'(count)) : per.PerRdData;
    end

    always_ff @(posedge CLK) begin
        if (RESET) overflow_q <= 1'b0;
        else overflow_q <= overflow_d;
    end

    assign per.PerValid = !empty;
    assign {per.PerAddr, per.PerData} = head;
endmodule

// File: doc/io_write_scheduler.md
Name: io_write_scheduler

Overview:
- Sits between the single-cycle MIPS memory-mapped I/O port (IOWriteEn/IOAddr/IOWriteData/IOReadData) and a slow peripheral bus with a valid/ready handshake, such as the snake display or LED/score registers.
- The CPU cannot stall, so single-cycle I/O writes are buffered in a small FIFO and replayed to the peripheral one handshake at a time.
- A status register at a reserved I/O address lets software poll busy/full/level and a sticky overflow flag.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2..16.
- STATUS_ADDR, 4'hF, I/O address of the status/control register; never forwarded to the peripheral.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- IOWriteEn  in  1  CPU I/O write strobe, one cycle per SW
- IOAddr  in  4  CPU I/O address
- IOWriteData  in  32  CPU I/O write data
- IOReadData  out  32  read data returned to CPU (combinational)
- PerValid  out  1  peripheral transfer valid
- PerAddr  out  4  peripheral register address
- PerData  out  32  peripheral write data
- PerReady  in  1  peripheral accepts the current transfer
- PerRdData  in  32  peripheral read data, passed through to the CPU

Behaviour:
- Reset, synchronous, at posedge CLK with RESET=1:
  - count=0, read/write pointers=0, overflow=0.
  - PerValid=0 from the next cycle; PerAddr/PerData are don't-care while PerValid=0.
  - Reset mid-handshake aborts the transfer: the entry is dropped and the peripheral must tolerate PerValid falling without PerReady.
- Push condition: IOWriteEn=1, IOAddr!=STATUS_ADDR, and the push is accepted.
  - Accepted when count<DEPTH, or when a pop occurs in the same cycle (full FIFO with simultaneous pop still accepts).
  - Entry stored = {IOAddr, IOWriteData}.
- Pop condition: PerValid=1 and PerReady=1 at posedge.
- PerValid = (count!=0). PerAddr/PerData = head entry, driven from registered storage.
  - Head is held stable while PerValid=1 and PerReady=0.
- Latency: a push into an empty FIFO at edge N makes PerValid=1 in cycle N+1, so a peripheral with constant PerReady=1 pops it at edge N+1.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. count width is clog2(DEPTH+1) and saturates at DEPTH.
- Rejected push (full, no pop): data dropped, overflow<=1 (sticky).
- Write to STATUS_ADDR:
  - Not queued.
  - If IOWriteData[2]=1, overflow<=0.
  - If overflow is being set by another event in the same cycle, set wins. This cannot occur because a single port allows only one write per cycle.
- Reads have no side effects, because the CPU has no read strobe.
  - IOAddr==STATUS_ADDR → IOReadData = status word.
  - Otherwise IOReadData = PerRdData.
- Status word layout:
  - [0] busy = (count!=0)
  - [1] full = (count==DEPTH)
  - [2] overflow
  - [8:4] count, zero-extended
  - all other bits 0
- No FSM beyond the FIFO state: EMPTY (count=0), ACTIVE (0<count<DEPTH), FULL (count=DEPTH), all derived from count.

Decomposition:
- Package io_ctrl_pkg:
  - STATUS_BUSY_BIT=0, STATUS_FULL_BIT=1, STATUS_OVF_BIT=2
  - STATUS_LEVEL_LSB=4, STATUS_LEVEL_W=5
  - default STATUS_ADDR
- Sub-module io_fifo: synchronous FIFO with parameters DEPTH and WIDTH=36. Ports: push, pop, din, dout (head), count, full, empty.
- The top level adds accept logic, the overflow flag and the read mux.

Test Plan:
- Single write, PerReady=1: write addr 3, data 32'h0000_00A5 at edge N → PerValid=1 with PerAddr=3, PerData=A5 during cycle N+1; popped at N+1; PerValid=0 at N+2; status reads 0.
- Backpressure, PerReady=0, 4 writes (data 1..4): status reads 32'h0000_0043 (count=4, full, busy). A 5th write sets overflow, status 32'h0000_0047. Raising PerReady drains 1,2,3,4 in order, one per cycle. Status then reads 32'h0000_0004.
- Write to STATUS_ADDR with data 32'h4 → overflow cleared, status 0, and PerValid never asserts.
- Full FIFO, PerReady=1, simultaneous write of 32'hDEAD → accepted with no overflow; count stays 4; DEAD emerges 4th after the held entries.
- RESET asserted while PerValid=1 and count=3 → next cycle PerValid=0, status 0. Post-reset write to addr 1 is delivered normally.
- Read mux: IOAddr=5, PerRdData=32'h1234_5678 → IOReadData=32'h1234_5678; IOAddr=STATUS_ADDR → status word.
